// File: rtl/bus_slave_resp.sv
// Wait-state bus slave: accepts one strobed access, stalls WAIT_CYCLES cycles,
// then completes it with a single-cycle active-low rdy_ pulse against a register file.
module bus_slave_resp #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned REG_ADDR_W  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_,
  input  logic        as_,
  input  logic        rw,
  input  logic [29:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rdy_,
  output logic        busy
);

  localparam int unsigned DEPTH = 2 ** REG_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [REG_ADDR_W-1:0]   idx;
  logic                    rw_q;
  logic [31:0]             wd_q;
  logic [31:0]             regs [DEPTH];

  // Upper address bits alias by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[29:REG_ADDR_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      rw_q  <= 1'b0;
      wd_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!cs_ && !as_) begin
            idx  <= addr[REG_ADDR_W-1:0];
            rw_q <= rw;
            wd_q <= wr_data;
            if (WAIT_CYCLES == 0) begin
              state <= ST_ACK;
            end else begin
              state <= ST_WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        ST_WAIT: begin
          // Both strobes high aborts; cs_ alone may be a decoder glitch.
          if (cs_ && as_) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == 4'd0) begin
            state <= ST_ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ACK: begin
          if (!rw_q) regs[idx] <= wd_q;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rdy_    = ~(state == ST_ACK);
  assign busy    = (state != ST_IDLE);
  assign rd_data = (state == ST_ACK && rw_q) ? regs[idx] : '0;

endmodule

// File: tb/tb_bus_slave_resp.sv
// Directed bench for bus_slave_resp: one instance with 2 wait states, one with none,
// sharing stimulus; sel picks which instance is strobed and observed.
module tb_bus_slave_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_, as_, rw;
  logic [29:0] addr;
  logic [31:0] wr_data;
  logic        sel;

  logic        cs_a, cs_b;
  logic [31:0] rd_data_a, rd_data_b, rd_data;
  logic        rdy_a, rdy_b, rdy_;
  logic        busy_a, busy_b, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign cs_a    = sel ? 1'b1 : cs_;
  assign cs_b    = sel ? cs_  : 1'b1;
  assign rd_data = sel ? rd_data_b : rd_data_a;
  assign rdy_    = sel ? rdy_b     : rdy_a;
  assign busy    = sel ? busy_b    : busy_a;

  bus_slave_resp #(.WAIT_CYCLES(2), .REG_ADDR_W(4)) dut_a (
    .clk(clk), .reset(reset), .cs_(cs_a), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data_a), .rdy_(rdy_a), .busy(busy_a)
  );

  bus_slave_resp #(.WAIT_CYCLES(0), .REG_ADDR_W(4)) dut_b (
    .clk(clk), .reset(reset), .cs_(cs_b), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data_b), .rdy_(rdy_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Strobe held until rdy_ is seen; latency counted in cycles after the accept edge.
  task automatic run_access(input logic r, input logic [29:0] a, input logic [31:0] wd,
                            input int exp_lat, input logic [31:0] exp_rd, input string tag);
    int k;
    bit found;
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; rw = r; addr = a; wr_data = wd;
    @(posedge clk);
    k = 0; found = 0;
    while (k < 20 && !found) begin
      @(negedge clk);
      k++;
      if (rdy_ === 1'b0) found = 1;
    end
    check({tag, "_lat"}, 32'(k), 32'(exp_lat));
    check({tag, "_rd"}, rd_data, exp_rd);
    cs_ = 1'b1; as_ = 1'b1;
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, rdy_, busy}, 32'h2);
  endtask

  initial begin
    reset = 1'b1; cs_ = 1'b1; as_ = 1'b1; rw = 1'b0; addr = '0; wr_data = '0; sel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1. idle after reset, both instances
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_a", {rd_data_a[31:2], ^rd_data_a, rdy_a, busy_a}, 32'h2);
      check("rst_b", {rd_data_b[31:2], ^rd_data_b, rdy_b, busy_b}, 32'h2);
    end

    // 2. WAIT_CYCLES = 2: write then read idx 3
    run_access(1'b0, 30'd3, 32'hDEADBEEF, 3, 32'h0, "wr3");
    run_access(1'b1, 30'd3, 32'h0, 3, 32'hDEADBEEF, "rd3");

    // 3. WAIT_CYCLES = 0: write idx 0, read alias idx 16
    sel = 1'b1;
    run_access(1'b0, 30'd0, 32'h1, 1, 32'h0, "wr0_b");
    run_access(1'b1, 30'd16, 32'h0, 1, 32'h1, "rd16_b");
    sel = 1'b0;

    // 4. abort in first WAIT cycle
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 30'd5; wr_data = 32'h55;
    @(negedge clk);
    check("abort_busy_wait", {31'd0, busy}, 32'h1);
    cs_ = 1'b1; as_ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_idle", {30'd0, rdy_, busy}, 32'h2);
    end
    run_access(1'b1, 30'd5, 32'h0, 3, 32'h0, "abort_rd5");

    // 5. reset during WAIT of a write
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 30'd5; wr_data = 32'hA5;
    @(negedge clk);
    check("rstw_rdy", {31'd0, rdy_}, 32'h1);
    reset = 1'b1; cs_ = 1'b1; as_ = 1'b1;
    @(negedge clk);
    check("rstw_idle", {30'd0, rdy_, busy}, 32'h2);
    reset = 1'b0;
    @(negedge clk);
    check("rstw_rdy2", {31'd0, rdy_}, 32'h1);
    run_access(1'b1, 30'd5, 32'h0, 3, 32'h0, "rstw_rd5");
    run_access(1'b1, 30'd3, 32'h0, 3, 32'h0, "rstw_rd3");

    // 6. strobe held through ACK: write idx 7, then read idx 7 accepted after one IDLE cycle
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 30'd7; wr_data = 32'h77;
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      check("b2b_wait1", {31'd0, rdy_}, 32'h1);
    end
    @(negedge clk);
    check("b2b_ack1", {31'd0, rdy_}, 32'h0);
    rw = 1'b1;
    @(negedge clk);
    check("b2b_gap", {30'd0, rdy_, busy}, 32'h2);
    repeat (2) begin
      @(negedge clk);
      check("b2b_wait2", {30'd0, rdy_, busy}, 32'h3);
    end
    @(negedge clk);
    check("b2b_ack2", {31'd0, rdy_}, 32'h0);
    check("b2b_rd7", rd_data, 32'h77);
    cs_ = 1'b1; as_ = 1'b1;
    @(negedge clk);
    check("b2b_end", {30'd0, rdy_, busy}, 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
